// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle shared by the memory responder and its masters.
// Master drives requests and write data; Slave drives readies and responses.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 responder serving one INCR/FIXED burst at a time onto a 1-cycle SRAM port.
// state   | meaning
// IDLE    | arbitrate AW vs AR, latch the winning request
// WR_DATA | accept W beats, one SRAM write per handshake
// WR_RESP | present B until accepted
// RD_REQ  | issue one SRAM read
// RD_DATA | present the read beat on R until accepted
module axi_mem_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  AXI_BUS.Slave                     slv,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0] mem_wdata_o,
  output logic [AXI_STRB_WIDTH-1:0] mem_be_o,
  input  logic [AXI_DATA_WIDTH-1:0] mem_rdata_i
);
  localparam int unsigned OFFS     = $clog2(AXI_STRB_WIDTH);
  localparam logic [2:0]  MAX_SIZE = 3'(OFFS);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d, addr_next;
  logic [7:0]                len_q, len_d, cnt_q, cnt_d;
  logic [2:0]                size_q, size_d, size_eff;
  logic [1:0]                burst_q, burst_d;
  logic [AXI_USER_WIDTH-1:0] user_q, user_d;
  logic                      rr_wr_q, rr_wr_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic                      rd_fresh_q;
  logic                      grant_wr, grant_rd, last_beat;

  assign size_eff  = (size_q > MAX_SIZE) ? MAX_SIZE : size_q;
  assign addr_next = (burst_q == 2'b00) ? addr_q
                                        : addr_q + (AXI_ADDR_WIDTH'(1) << size_eff);
  assign last_beat = (cnt_q == len_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      user_q     <= '0;
      cnt_q      <= '0;
      rr_wr_q    <= 1'b0;
      rdata_q    <= '0;
      rd_fresh_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      user_q     <= user_d;
      cnt_q      <= cnt_d;
      rr_wr_q    <= rr_wr_d;
      rd_fresh_q <= (state_q == RD_REQ);
      if (rd_fresh_q) rdata_q <= mem_rdata_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    user_d       = user_q;
    cnt_d        = cnt_q;
    rr_wr_d      = rr_wr_q;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;
    slv.aw_ready = 1'b0;
    slv.ar_ready = 1'b0;
    slv.w_ready  = 1'b0;
    slv.b_valid  = 1'b0;
    slv.r_valid  = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    case (state_q)
      IDLE: begin
        // rr_wr_q only flips on a genuine AW/AR conflict
        if (slv.aw_valid && slv.ar_valid) begin
          grant_wr = rr_wr_q;
          grant_rd = !rr_wr_q;
          rr_wr_d  = !rr_wr_q;
        end else begin
          grant_wr = slv.aw_valid;
          grant_rd = slv.ar_valid;
        end
        slv.aw_ready = grant_wr;
        slv.ar_ready = grant_rd;
        if (grant_wr) begin
          id_d    = slv.aw_id;
          addr_d  = slv.aw_addr;
          len_d   = slv.aw_len;
          size_d  = slv.aw_size;
          burst_d = slv.aw_burst;
          user_d  = slv.aw_user;
          cnt_d   = '0;
          state_d = WR_DATA;
        end else if (grant_rd) begin
          id_d    = slv.ar_id;
          addr_d  = slv.ar_addr;
          len_d   = slv.ar_len;
          size_d  = slv.ar_size;
          burst_d = slv.ar_burst;
          user_d  = slv.ar_user;
          cnt_d   = '0;
          state_d = RD_REQ;
        end
      end
      WR_DATA: begin
        slv.w_ready = 1'b1;
        if (slv.w_valid) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_wdata_o = slv.w_data;
          mem_be_o    = slv.w_strb;
          if (last_beat) begin
            state_d = WR_RESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = addr_next;
          end
        end
      end
      WR_RESP: begin
        slv.b_valid = 1'b1;
        if (slv.b_ready) state_d = IDLE;
      end
      RD_REQ: begin
        mem_req_o = 1'b1;
        state_d   = RD_DATA;
      end
      RD_DATA: begin
        slv.r_valid = 1'b1;
        if (slv.r_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = addr_next;
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o = addr_q[MEM_ADDR_WIDTH+OFFS-1:OFFS];

  assign slv.b_id   = id_q;
  assign slv.b_user = user_q;
  assign slv.b_resp = 2'b00;
  assign slv.r_id   = id_q;
  assign slv.r_user = user_q;
  assign slv.r_resp = 2'b00;
  assign slv.r_last = (state_q == RD_DATA) && last_beat;
  // SRAM data arrives in the first RD_DATA cycle; afterwards the captured copy is held
  assign slv.r_data = rd_fresh_q ? mem_rdata_i : rdata_q;

  logic unused_ok;
  assign unused_ok = ^{slv.aw_lock, slv.aw_cache, slv.aw_prot, slv.aw_qos, slv.aw_region,
                       slv.ar_lock, slv.ar_cache, slv.ar_prot, slv.ar_qos, slv.ar_region,
                       slv.w_last, slv.w_user};
endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized bench for axi_mem_slave with a transaction-level model, a shadow
// memory and a per-cycle monitor comparing SRAM requests and B/R beats.
module tb_axi_mem_slave;
  localparam int AW = 32, DW = 64, IW = 10, UW = 6, MW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
            .AXI_USER_WIDTH(UW)) bus ();

  logic          mem_req, mem_we;
  logic [MW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [7:0]    mem_be;

  axi_mem_slave #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                  .AXI_USER_WIDTH(UW), .MEM_ADDR_WIDTH(MW)) dut (
    .clk_i(clk), .rst_i(rst), .slv(bus),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata));

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void flag(input string name, input string what);
    n_checks++;
    $display("FAIL %s: got %s at %0t", name, what, $time);
  endfunction

  // ---------------- memories: DUT-side SRAM and model shadow ----------------
  logic [63:0] sram   [int unsigned];
  logic [63:0] shadow [int unsigned];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rd_sram(input int unsigned a);
    return sram.exists(a) ? sram[a] : 64'h0;
  endfunction

  function automatic logic [63:0] rd_shadow(input int unsigned a);
    return shadow.exists(a) ? shadow[a] : 64'h0;
  endfunction

  always @(posedge clk) begin
    if (mem_req && mem_we) sram[int'(mem_addr)] = merge(rd_sram(int'(mem_addr)), mem_wdata, mem_be);
    mem_rdata <= (mem_req && !mem_we) ? rd_sram(int'(mem_addr)) : {$urandom, $urandom};
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {logic we; logic [15:0] addr; logic [63:0] data; logic [7:0] be;} mem_op_t;
  typedef struct packed {logic [9:0] id; logic [5:0] user; logic [63:0] data; logic last;} beat_t;

  mem_op_t exp_mem[$];
  beat_t   exp_r[$];
  beat_t   exp_b[$];
  mem_op_t seen_mem[$];
  int      seen_cyc[$];
  beat_t   seen_r[$];
  logic [63:0] fixed_wd[$];
  bit      rr_model_wr = 1'b0;

  // Word touched by beat i: FIXED stays put, otherwise i steps of the clamped size.
  function automatic logic [15:0] beat_word(input logic [31:0] addr, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    int s;
    s = (size > 3'd3) ? 3 : int'(size);
    a = (burst == 2'b00) ? addr : addr + 32'(i) * (32'd1 << s);
    return a[18:3];
  endfunction

  // ---------------- monitor ----------------
  int    cyc = 0;
  logic  prev_rv = 0, prev_rr = 0, prev_bv = 0, prev_br = 0;
  beat_t prev_rb, prev_bb, cur_r, cur_b;
  mem_op_t e, obs;
  beat_t   eb;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_rv = 0;
      prev_bv = 0;
    end else begin
      if (bus.aw_valid && bus.ar_valid)
        check("grant_exclusive", 128'(bus.aw_ready & bus.ar_ready), 128'(0));
      if (mem_req) begin
        obs = '{we: mem_we, addr: mem_addr, data: mem_wdata, be: mem_be};
        seen_mem.push_back(obs);
        seen_cyc.push_back(cyc);
        if (exp_mem.size() == 0) flag("mem_req_unexpected", "req with nothing pending");
        else begin
          e = exp_mem.pop_front();
          check("mem_we", 128'(mem_we), 128'(e.we));
          check("mem_addr", 128'(mem_addr), 128'(e.addr));
          if (e.we) begin
            check("mem_wdata", 128'(mem_wdata), 128'(e.data));
            check("mem_be", 128'(mem_be), 128'(e.be));
          end
        end
      end
      cur_r = '{id: bus.r_id, user: bus.r_user, data: bus.r_data, last: bus.r_last};
      if (prev_rv && !prev_rr) begin
        check("r_hold_valid", 128'(bus.r_valid), 128'(1));
        check("r_hold_stable", 128'(cur_r), 128'(prev_rb));
      end
      if (bus.r_valid && exp_r.size() == 0) flag("r_unexpected", "r_valid with no read pending");
      else if (bus.r_valid && bus.r_ready) begin
        eb = exp_r.pop_front();
        seen_r.push_back(cur_r);
        check("r_beat", 128'(cur_r), 128'(eb));
        check("r_resp", 128'(bus.r_resp), 128'(0));
      end
      prev_rv = bus.r_valid; prev_rr = bus.r_ready; prev_rb = cur_r;

      cur_b = '{id: bus.b_id, user: bus.b_user, data: 64'h0, last: 1'b0};
      if (prev_bv && !prev_br) begin
        check("b_hold_valid", 128'(bus.b_valid), 128'(1));
        check("b_hold_stable", 128'(cur_b), 128'(prev_bb));
      end
      if (bus.b_valid && exp_b.size() == 0) flag("b_unexpected", "b_valid with no write pending");
      else if (bus.b_valid && bus.b_ready) begin
        eb = exp_b.pop_front();
        check("b_id_user", 128'(cur_b), 128'(eb));
        check("b_resp", 128'(bus.b_resp), 128'(0));
      end
      prev_bv = bus.b_valid; prev_br = bus.b_ready; prev_bb = cur_b;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int ch, input string name);
    int n;
    logic hs;
    n = 0;
    forever begin
      @(negedge clk);
      case (ch)
        0:       hs = bus.aw_valid && bus.aw_ready;
        1:       hs = bus.ar_valid && bus.ar_ready;
        default: hs = bus.w_valid && bus.w_ready;
      endcase
      @(posedge clk); #1;
      if (hs) break;
      if (++n > 3000) begin flag(name, "handshake timeout"); break; end
    end
    case (ch)
      0:       bus.aw_valid = 1'b0;
      1:       bus.ar_valid = 1'b0;
      default: bus.w_valid  = 1'b0;
    endcase
  endtask

  task automatic drive_aw(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [5:0] user);
    bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size;
    bus.aw_burst = burst; bus.aw_user = user; bus.aw_valid = 1'b1;
  endtask

  task automatic drive_ar(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [5:0] user);
    bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size;
    bus.ar_burst = burst; bus.ar_user = user; bus.ar_valid = 1'b1;
  endtask

  task automatic model_ar(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [5:0] user);
    logic [15:0] w;
    for (int i = 0; i <= int'(len); i++) begin
      w = beat_word(addr, i, size, burst);
      exp_mem.push_back('{we: 1'b0, addr: w, data: 64'h0, be: 8'h0});
      exp_r.push_back('{id: id, user: user, data: rd_shadow(int'(w)), last: (i == int'(len))});
    end
  endtask

  task automatic send_w(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input int gap_max, input int nb);
    logic [15:0] w;
    logic [63:0] d;
    logic [7:0]  be;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      if (fixed_wd.size() != 0) begin d = fixed_wd.pop_front(); be = 8'hFF; end
      else begin
        d  = {$urandom, $urandom};
        be = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      end
      w = beat_word(addr, i, size, burst);
      exp_mem.push_back('{we: 1'b1, addr: w, data: d, be: be});
      shadow[int'(w)] = merge(rd_shadow(int'(w)), d, be);
      bus.w_data = d; bus.w_strb = be; bus.w_last = (i == int'(len)); bus.w_valid = 1'b1;
      wait_hs(2, "w_handshake");
    end
  endtask

  task automatic recv_b(input int stall);
    int st, n;
    logic hs;
    st = 0; n = 0; hs = 1'b0;
    while (!hs) begin
      bus.b_ready = (st >= stall) ? ($urandom_range(0, 2) != 0) : 1'b0;
      @(negedge clk);
      hs = bus.b_valid && bus.b_ready;
      if (bus.b_valid && !bus.b_ready) st++;
      @(posedge clk); #1;
      if (++n > 3000) begin flag("b_handshake", "timeout"); break; end
    end
    bus.b_ready = 1'b0;
  endtask

  task automatic recv_r(input int nb, input int stall_at);
    int got, n, st;
    logic hs;
    got = 0; n = 0; st = 0;
    while (got < nb) begin
      if (got == stall_at && st < 5) bus.r_ready = 1'b0;
      else bus.r_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs = bus.r_valid && bus.r_ready;
      if (got == stall_at && bus.r_valid && !bus.r_ready) st++;
      @(posedge clk); #1;
      if (hs) got++;
      if (++n > 5000) begin flag("r_handshake", "timeout"); break; end
    end
    bus.r_ready = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [5:0] user,
                          input int gap_max, input int b_stall);
    exp_b.push_back('{id: id, user: user, data: 64'h0, last: 1'b0});
    drive_aw(id, addr, len, size, burst, user);
    wait_hs(0, "aw_handshake");
    send_w(addr, len, size, burst, gap_max, int'(len) + 1);
    recv_b(b_stall);
  endtask

  task automatic do_read(input logic [9:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [5:0] user,
                         input int stall_at);
    model_ar(id, addr, len, size, burst, user);
    drive_ar(id, addr, len, size, burst, user);
    wait_hs(1, "ar_handshake");
    recv_r(int'(len) + 1, stall_at);
  endtask

  task automatic clear_seen();
    seen_mem.delete(); seen_cyc.delete(); seen_r.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_req"}, 128'(mem_req), 128'(0));
    check({tag, "_ready_valid"}, 128'({bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid,
                                      bus.r_valid}), 128'(0));
    check({tag, "_data_id"}, 128'({bus.b_id, bus.r_id, bus.r_data, bus.r_last, bus.b_user,
                                   bus.r_user, mem_addr, mem_wdata, mem_be}), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] ra;
  initial begin
    bus.aw_valid = 0; bus.ar_valid = 0; bus.w_valid = 0; bus.b_ready = 0; bus.r_ready = 0;
    bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
    bus.aw_lock = 0; bus.aw_cache = 0; bus.aw_prot = 0; bus.aw_qos = 0; bus.aw_region = 0;
    bus.aw_user = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 0;
    bus.ar_burst = 0; bus.ar_lock = 0; bus.ar_cache = 0; bus.ar_prot = 0; bus.ar_qos = 0;
    bus.ar_region = 0; bus.ar_user = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0;
    bus.w_user = 0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;

    // first post-reset cycle: both request, read must win
    model_ar(10'd3, 32'h300, 8'd1, 3'd3, 2'b01, 6'd1);
    drive_ar(10'd3, 32'h300, 8'd1, 3'd3, 2'b01, 6'd1);
    exp_b.push_back('{id: 10'd4, user: 6'd2, data: 64'h0, last: 1'b0});
    drive_aw(10'd4, 32'h308, 8'd0, 3'd3, 2'b01, 6'd2);
    @(negedge clk);
    check("conflict1_ar_ready", 128'(bus.ar_ready), 128'(1));
    check("conflict1_aw_ready", 128'(bus.aw_ready), 128'(0));
    rr_model_wr = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    recv_r(2, -1);
    wait_hs(0, "aw_after_read");
    send_w(32'h308, 8'd0, 3'd3, 2'b01, 0, 1);
    recv_b(0);

    // second conflict goes to the write
    exp_b.push_back('{id: 10'd6, user: 6'd3, data: 64'h0, last: 1'b0});
    drive_aw(10'd6, 32'h310, 8'd0, 3'd3, 2'b01, 6'd3);
    drive_ar(10'd7, 32'h310, 8'd0, 3'd3, 2'b01, 6'd4);
    @(negedge clk);
    check("conflict2_aw_ready", 128'(bus.aw_ready), 128'(rr_model_wr));
    check("conflict2_ar_ready", 128'(bus.ar_ready), 128'(!rr_model_wr));
    rr_model_wr = !rr_model_wr;
    tick();
    bus.aw_valid = 1'b0;
    send_w(32'h310, 8'd0, 3'd3, 2'b01, 1, 1);
    recv_b(0);
    model_ar(10'd7, 32'h310, 8'd0, 3'd3, 2'b01, 6'd4);
    wait_hs(1, "ar_after_write");
    recv_r(1, -1);

    // single write / read
    clear_seen();
    fixed_wd.push_back(64'hDEADBEEF_CAFEF00D);
    do_write(10'h155, 32'h100, 8'd0, 3'd3, 2'b01, 6'd5, 0, 0);
    do_read(10'h0AA, 32'h100, 8'd0, 3'd3, 2'b01, 6'd6, -1);
    check("single_wr_word", 128'(seen_mem[0].addr), 128'(16'h20));
    check("single_rd_data", 128'(seen_r[0].data), 128'(64'hDEADBEEF_CAFEF00D));
    check("single_rd_last", 128'(seen_r[0].last), 128'(1));

    // INCR burst, back-to-back W beats
    clear_seen();
    do_write(10'd9, 32'h0, 8'd3, 3'd3, 2'b01, 6'd0, 0, 0);
    check("incr_words", 128'({seen_mem[0].addr, seen_mem[1].addr, seen_mem[2].addr,
                              seen_mem[3].addr}), 128'(64'h0000_0001_0002_0003));
    check("incr_consecutive", 128'(seen_cyc[3] - seen_cyc[0]), 128'(3));
    clear_seen();
    do_read(10'd11, 32'h0, 8'd3, 3'd3, 2'b01, 6'd0, -1);
    check("incr_r_last", 128'({seen_r[0].last, seen_r[1].last, seen_r[2].last, seen_r[3].last}),
          128'(4'b0001));
    check("incr_r_id", 128'(seen_r[2].id), 128'(10'd11));

    // FIXED read and narrow INCR write
    clear_seen();
    do_read(10'd12, 32'h40, 8'd2, 3'd3, 2'b00, 6'd0, -1);
    check("fixed_words", 128'({seen_mem[0].addr, seen_mem[1].addr, seen_mem[2].addr}),
          128'(48'h0008_0008_0008));
    clear_seen();
    do_write(10'd13, 32'h0, 8'd1, 3'd2, 2'b01, 6'd0, 1, 0);
    check("narrow_words", 128'({seen_mem[0].addr, seen_mem[1].addr}), 128'(32'h0));

    // backpressure on B and mid-burst R
    do_write(10'd14, 32'h500, 8'd3, 3'd3, 2'b01, 6'd7, 2, 5);
    clear_seen();
    do_read(10'd15, 32'h500, 8'd3, 3'd3, 2'b01, 6'd8, 1);
    check("stall_req_count", 128'(seen_mem.size()), 128'(4));
    check("stall_beat_count", 128'(seen_r.size()), 128'(4));

    // reset during beat 2 of an 8-beat write
    drive_aw(10'd16, 32'h600, 8'd7, 3'd3, 2'b01, 6'd9);
    wait_hs(0, "aw_reset_test");
    send_w(32'h600, 8'd7, 3'd3, 2'b01, 0, 2);
    bus.w_data = 64'h1234; bus.w_strb = 8'hFF; bus.w_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("midburst_reset");
    bus.w_valid = 1'b0;
    rr_model_wr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check_idle_outputs("after_reset");
    tick();
    do_write(10'd17, 32'h700, 8'd2, 3'd3, 2'b01, 6'd10, 1, 1);
    do_read(10'd18, 32'h600, 8'd3, 3'd3, 2'b01, 6'd11, -1);

    // longest burst
    clear_seen();
    do_write(10'd19, 32'h8000, 8'd255, 3'd3, 2'b01, 6'd12, 0, 0);
    check("len255_wr_beats", 128'(seen_mem.size()), 128'(256));
    clear_seen();
    do_read(10'd20, 32'h8000, 8'd255, 3'd3, 2'b01, 6'd13, 100);
    check("len255_rd_beats", 128'(seen_r.size()), 128'(256));

    // random traffic
    for (int t = 0; t < 40; t++) begin
      ra = 32'($urandom_range(0, 'h7ff));
      if ($urandom_range(0, 3) == 0) ra[31:19] = 13'($urandom);
      if ($urandom_range(0, 1) != 0)
        do_write(10'($urandom), ra, 8'($urandom_range(0, 12)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 2)), 6'($urandom), 2, $urandom_range(0, 3));
      else
        do_read(10'($urandom), ra, 8'($urandom_range(0, 12)), 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 2)), 6'($urandom), $urandom_range(0, 4));
    end

    repeat (5) tick();
    check("exp_mem_drained", 128'(exp_mem.size()), 128'(0));
    check("exp_r_drained", 128'(exp_r.size()), 128'(0));
    check("exp_b_drained", 128'(exp_b.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
